// File: rtl/counter_enable_gen.sv
// -----------------------------------------------------------------------------
// counter_enable_gen
//
// Enable-pulse generator feeding the enable input of a downstream 4-bit
// counter. Control strobes (start/stop/step) and a hold level are turned into
// a prescaled stream of single-cycle enable pulses. A run is either free-running
// (burst length 0) or limited to a fixed number of pulses. Outside a run, a
// step strobe issues one pulse for single-stepping the counter.
//
// Parameters
//   PRESCALE_W  width of the prescale period field
//   BURST_W     width of burst length and pulse count
//
// Ports
//   clk_i         system clock, rising edge
//   reset_i       asynchronous active-high reset
//   start_i       strobe: begin a run from IDLE (latches prescale/burst_len)
//   stop_i        strobe: abort a run, highest priority
//   step_i        strobe: one enable pulse while IDLE
//   hold_i        level: freeze the prescaler while high during a run
//   prescale_i    pulse period minus one (P)
//   burst_len_i   pulses per run (B), 0 = free-run
//   enable_o      registered single-cycle enable pulse
//   running_o     high while in RUN or HOLD
//   done_o        registered single-cycle pulse on burst completion
//   pulse_cnt_o   pulses issued since the last start (wraps)
// -----------------------------------------------------------------------------
module counter_enable_gen #(
  parameter int PRESCALE_W = 8,
  parameter int BURST_W    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  step_i,
  input  logic                  hold_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [BURST_W-1:0]    burst_len_i,
  output logic                  enable_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic [BURST_W-1:0]    pulse_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;       // prescaler count
  logic [PRESCALE_W-1:0] p_q, p_d;         // latched prescale
  logic [BURST_W-1:0]    b_q, b_d;         // latched burst length
  logic [BURST_W-1:0]    cnt_q, cnt_d;     // pulses since start
  logic                  enable_q, enable_d;
  logic                  done_q, done_d;

  logic [BURST_W-1:0]    cnt_inc;

  assign cnt_inc = cnt_q + BURST_W'(1);

  // State register and all output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      p_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      p_q      <= p_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. enable/done default low so every pulse lasts one cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    p_d      = p_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          p_d     = prescale_i;
          b_d     = burst_len_i;
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (step_i) begin
          enable_d = 1'b1;
        end
      end

      // RUN and HOLD share the same decision tree: hold is a level, so the
      // edge on which it is seen low already advances the prescaler. That way
      // H cycles of hold shift every later pulse by exactly H cycles.
      S_RUN, S_HOLD: begin
        if (stop_i) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else if (hold_i) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          if (pc_q == p_q) begin
            pc_d     = '0;
            enable_d = 1'b1;
            cnt_d    = cnt_inc;
            if ((b_q != '0) && (cnt_inc == b_q)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            pc_d = pc_q + PRESCALE_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign enable_o    = enable_q;
  assign done_o      = done_q;
  assign pulse_cnt_o = cnt_q;
  assign running_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_counter_enable_gen
//
// Scoreboard bench: stimulus pushes the expected pulse (cycle, done, count,
// running) into a queue when it issues a command; a monitor on the falling
// edge pops and compares whenever enable or done is high. Any pulse with no
// expectation queued is an error. A few status values are checked directly.
// -----------------------------------------------------------------------------
module tb_counter_enable_gen;

  localparam int PW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i, stop_i, step_i, hold_i;
  logic [PW-1:0] prescale_i;
  logic [BW-1:0] burst_len_i;
  logic          enable_o, running_o, done_o;
  logic [BW-1:0] pulse_cnt_o;

  counter_enable_gen #(.PRESCALE_W(PW), .BURST_W(BW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .step_i      (step_i),
    .hold_i      (hold_i),
    .prescale_i  (prescale_i),
    .burst_len_i (burst_len_i),
    .enable_o    (enable_o),
    .running_o   (running_o),
    .done_o      (done_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic     done;
    logic [3:0] cnt;
    logic     run;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   ds_cnt  = 0;   // model of the downstream 4-bit counter
  int   e0      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every enable/done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_i && (enable_o || done_o)) begin
      checks++;
      if (enable_o) ds_cnt = (ds_cnt + 1) % 16;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d en=%0b done=%0b cnt=%0d (no pulse expected)",
                 cyc, enable_o, done_o, pulse_cnt_o);
      end else begin
        e = exp_q.pop_front();
        if (!(enable_o && cyc == e.cyc && done_o == e.done &&
              pulse_cnt_o == e.cnt && running_o == e.run)) begin
          errors++;
          $display("FAIL pulse got cyc=%0d en=%0b done=%0b cnt=%0d run=%0b, want cyc=%0d en=1 done=%0b cnt=%0d run=%0b",
                   cyc, enable_o, done_o, pulse_cnt_o, running_o, e.cyc, e.done, e.cnt, e.run);
        end else begin
          $display("pulse ok cyc=%0d done=%0b cnt=%0d run=%0b", cyc, done_o, pulse_cnt_o, running_o);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end else begin
      $display("check ok %s = %0d", name, act);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic d, input int n, input logic r);
    exp_t e;
    e.cyc  = c;
    e.done = d;
    e.cnt  = 4'(n);
    e.run  = r;
    exp_q.push_back(e);
  endtask

  // Issue start at a falling edge; returns on the falling edge after the
  // sampling edge, with e0 set to that sampling edge's cycle number.
  task automatic do_start(input int p, input int b);
    prescale_i  = 8'(p);
    burst_len_i = 4'(b);
    start_i     = 1'b1;
    e0          = cyc + 1;
    wait_n(1);
    start_i     = 1'b0;
  endtask

  initial begin
    int ds_base;
    reset_i = 1'b1; start_i = 0; stop_i = 0; step_i = 0; hold_i = 0;
    prescale_i = '0; burst_len_i = '0;

    #1;
    chk("reset_enable",  enable_o,    0);
    chk("reset_running", running_o,   0);
    chk("reset_done",    done_o,      0);
    chk("reset_cnt",     pulse_cnt_o, 0);
    wait_n(2);
    reset_i = 1'b0;
    wait_n(2);

    // Burst P=3 B=5: pulses every 4 cycles, done with the fifth.
    do_start(3, 5);
    chk("burst_running", running_o, 1);
    for (int k = 1; k <= 5; k++) push(e0 + 4*k, (k == 5), k, (k != 5));
    wait_n(22);
    chk("burst_cnt",     pulse_cnt_o, 5);
    chk("burst_running_end", running_o, 0);
    chk("burst_done_end", done_o, 0);

    // Free-run P=0: enable every cycle, count wraps at pulse 16.
    do_start(0, 0);
    ds_base = ds_cnt;
    for (int k = 1; k <= 20; k++) push(e0 + k, 1'b0, k % 16, 1'b1);
    wait_n(20);
    stop_i = 1'b1;
    wait_n(1);
    stop_i = 1'b0;
    chk("free_cnt",      pulse_cnt_o, 4);
    chk("free_running",  running_o, 0);
    chk("downstream_cnt", (ds_cnt - ds_base + 16) % 16, 4);

    // Hold P=4 B=3: 7 hold cycles right after pulse 1 push pulses 2,3 by 7.
    do_start(4, 3);
    push(e0 + 5,  1'b0, 1, 1'b1);
    push(e0 + 17, 1'b0, 2, 1'b1);
    push(e0 + 22, 1'b1, 3, 1'b0);
    wait_n(5);
    hold_i = 1'b1;
    wait_n(7);
    hold_i = 1'b0;
    wait_n(12);
    chk("hold_running_end", running_o, 0);

    // Stop exactly when pc==P (P=2): third pulse suppressed.
    do_start(2, 0);
    push(e0 + 3, 1'b0, 1, 1'b1);
    push(e0 + 6, 1'b0, 2, 1'b1);
    wait_n(8);
    stop_i = 1'b1;
    wait_n(1);
    stop_i = 1'b0;
    chk("stop_running", running_o, 0);
    wait_n(4);
    chk("stop_cnt",  pulse_cnt_o, 2);
    chk("stop_done", done_o, 0);

    // start+stop together in IDLE: stays IDLE.
    prescale_i = '0; burst_len_i = '0;
    start_i = 1'b1; stop_i = 1'b1;
    wait_n(1);
    start_i = 1'b0; stop_i = 1'b0;
    chk("startstop_running", running_o, 0);
    wait_n(5);
    chk("startstop_cnt", pulse_cnt_o, 2);

    // start+step together: run starts, no step pulse.
    prescale_i = 8'd1; burst_len_i = 4'd2;
    start_i = 1'b1; step_i = 1'b1;
    e0 = cyc + 1;
    wait_n(1);
    start_i = 1'b0; step_i = 1'b0;
    chk("startstep_running", running_o, 1);
    push(e0 + 2, 1'b0, 1, 1'b1);
    push(e0 + 4, 1'b1, 2, 1'b0);
    wait_n(6);

    // Step in IDLE: one pulse after each strobe, count unchanged.
    for (int i = 0; i < 3; i++) begin
      step_i = 1'b1;
      push(cyc + 1, 1'b0, 2, 1'b0);
      wait_n(1);
      step_i = 1'b0;
      wait_n(4);
    end
    chk("step_running", running_o, 0);
    chk("step_cnt", pulse_cnt_o, 2);

    // Step during RUN is ignored (P=5 B=1).
    do_start(5, 1);
    push(e0 + 6, 1'b1, 1, 1'b0);
    wait_n(2);
    step_i = 1'b1;
    wait_n(1);
    step_i = 1'b0;
    wait_n(6);

    // Asynchronous reset mid-run, between clock edges.
    do_start(0, 0);
    for (int k = 1; k <= 3; k++) push(e0 + k, 1'b0, k, 1'b1);
    wait_n(3);
    chk("prereset_enable", enable_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_enable",  enable_o,    0);
    chk("async_running", running_o,   0);
    chk("async_done",    done_o,      0);
    chk("async_cnt",     pulse_cnt_o, 0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    wait_n(50);
    chk("postreset_running", running_o, 0);
    chk("postreset_cnt", pulse_cnt_o, 0);

    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_enable_gen.md
# counter_enable_gen

Enable-pulse generator that sits directly upstream of the 4-bit counter and drives its `enable` input. It converts start/stop/step/hold control strobes into a prescaled stream of single-cycle enable pulses. The stream can be free-running or limited to a fixed burst length, with one-shot stepping for debug. It reports run status, pulses issued and burst completion.

## Interface
- `PRESCALE_W`, 8: width of the prescale period field.
- `BURST_W`, 4: width of the burst length and pulse count; matches the 4-bit counter.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle strobe; begins a run from IDLE.
- `stop`  in  1  single-cycle strobe; aborts a run (RUN or HOLD → IDLE).
- `step`  in  1  single-cycle strobe; issues one enable pulse while IDLE.
- `hold`  in  1  level; freezes the prescaler while high during a run.
- `prescale`  in  PRESCALE_W  pulse period minus 1 (P); latched on start.
- `burst_len`  in  BURST_W  pulses per run (B); 0 = free-run; latched on start.
- `enable`  out  1  registered single-cycle pulse to the downstream counter `enable`.
- `running`  out  1  high in RUN or HOLD.
- `done`  out  1  registered single-cycle pulse on burst completion.
- `pulse_cnt`  out  BURST_W  pulses issued since the last start, wrap modulo 2^BURST_W.

## Operation
- Reset (async, immediate): state IDLE; `enable`=0, `done`=0, `running`=0, `pulse_cnt`=0, prescaler pc=0, latched P=0, latched B=0.
- States are IDLE, RUN and HOLD. `running` = (state != IDLE).
- **IDLE**
  - `stop` → stay IDLE.
  - Else `start` → latch P and B, clear pc and `pulse_cnt`, go to RUN.
  - Else `step` → `enable`=1 for one cycle, stay IDLE; `pulse_cnt` unchanged.
- **RUN**
  - `stop` → IDLE; `enable`=0, `done`=0, pc=0; `pulse_cnt` holds its value.
  - Else `hold` → HOLD; pc frozen, `enable`=0.
  - Else if pc==P: pc←0, `enable`←1, `pulse_cnt`←`pulse_cnt`+1.
    - If B≠0 and `pulse_cnt`+1==B: `done`←1 and go to IDLE on the same edge.
  - Else pc←pc+1, `enable`←0.
- **HOLD**
  - `stop` → IDLE.
  - Else if `hold` is low → RUN; pc resumes from its frozen value.
  - Outputs `enable`=0 and `done`=0.
- Strobe priority: `stop` > `start` > `step`. `start` and `step` are ignored outside IDLE. `hold` is ignored in IDLE.
- `prescale` and `burst_len` changes during a run have no effect until the next `start`.
- Arithmetic: pc is PRESCALE_W bits, compared equal to P, never overflows. `pulse_cnt` wraps 2^BURST_W−1 → 0 in free-run.

## Timing
- All outputs are registered; there is no combinational input→output path.
- `start` sampled at edge E0: `running`=1 after E0. The first `enable` is high after edge E0+P+1. Subsequent pulses are every P+1 cycles, each high for exactly 1 cycle.
- P=0: `enable` high continuously from E0+1 to the end of the run.
- Burst of B: exactly B enable pulses. `done` and the last `enable` are high in the same cycle, and `running`=0 from that same edge.
- HOLD of H cycles delays all later pulses by exactly H cycles.
- `step` sampled at edge E: `enable` high for the cycle after E.
- `stop` sampled at edge E: from E onward `enable`=0, `running`=0. A pulse that would have fired at E is suppressed.
- Reset asserted mid-run: outputs return to their reset values asynchronously, without waiting for a clock edge. After reset deasserts, nothing happens until the next `start`.

## Test plan
- Reset: assert `reset` mid-run between clock edges → `enable`, `running`, `done`, `pulse_cnt` all 0 before the next edge. After deassert with no strobes, `enable` stays 0 for 50 cycles.
- Burst: P=3, B=5, `start` → 5 pulses spaced 4 cycles apart, first at start+4. `done` coincides with pulse 5; `pulse_cnt`=5; `running` drops on the same edge.
- Free-run wrap: P=0, B=0, run 20 cycles → `enable` high every cycle; `pulse_cnt` goes 15→0 at pulse 16 and reads 4 at cycle 20. Downstream counter reads 4.
- Hold: P=4, B=3; assert `hold` 7 cycles immediately after the first pulse → pulses 2 and 3 delayed by exactly 7 cycles vs. the unheld run. `done` with pulse 3.
- Stop and priority:
  - `stop` at pc==P (P=2, B=0) → that pulse is suppressed; `pulse_cnt` holds; `done`=0.
  - `start`+`stop` together in IDLE → stays IDLE.
  - `start`+`step` together → run starts, no step pulse.
- Step: in IDLE, 3 `step` strobes 5 cycles apart → 3 single-cycle enables, each 1 cycle after its strobe. `running`=0 and `pulse_cnt` unchanged throughout. `step` during RUN is ignored.
